sar_search: RTL and testbench
=============================

Name: sar_search

Overview:
- Sequential initiator that drives the far end of the team's signed-comparator interface (gt/lt/eq flags).
- Binary-searches a signed WIDTH-bit hidden target: issues a guess, consumes the comparator verdict (target vs guess), narrows bounds, repeats until eq.
- Sits between a control master (start/done) and any comparator instance (e.g. subtractor-based signed compare), connected via a valid handshake.

Parameters:
- WIDTH, 4, operand width in bits, two's complement; legal range 2..16.
- TIMEOUT, 15, cycles to wait for cmp_valid before abort; used only with SAR_TIMEOUT_EN.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request to begin a search; ignored unless idle
- guess  out  WIDTH  current probe value (signed), stable while guess_valid=1
- guess_valid  out  1  probe outstanding; comparator verdict awaited
- cmp_valid  in  1  verdict valid this cycle; sampled only while guess_valid=1
- cmp_gt  in  1  target > guess
- cmp_lt  in  1  target < guess
- cmp_eq  in  1  target == guess
- busy  out  1  high in PROBE state
- done  out  1  one-cycle pulse when search ends
- found  out  1  valid with done: target located
- err  out  1  valid with done: protocol error (non-one-hot flags or timeout)
- result  out  WIDTH  located value; held until next start
- probes  out  $clog2(WIDTH+2)  verdicts consumed in last search; held until next start

Behaviour:
- Reset (async, rst_n=0): state=IDLE; guess, guess_valid, busy, done, found, err, result, probes all 0. Reset mid-search abandons it immediately, with no done pulse.
- Internal bounds lo, hi: WIDTH+1 bits signed. Midpoint = (lo+hi) arithmetic-shifted right 1, computed in WIDTH+2 bits (floor toward minus infinity). guess = low WIDTH bits of the midpoint.
- IDLE: done=0. On start, go to PROBE with:
  - lo=-2^(WIDTH-1), hi=2^(WIDTH-1)-1;
  - probes=0, found=0, err=0, result=0.
- PROBE: guess_valid=1, busy=1. guess updates only on the cycle after a verdict. On cmp_valid=1:
  - exactly cmp_eq: result=guess, found=1, go to DONE.
  - exactly cmp_gt: lo=guess+1.
  - exactly cmp_lt: hi=guess-1.
  - not one-hot: err=1, found=0, go to DONE.
  - probes increments on every consumed verdict, including the final one.
  - After a gt/lt update, if new lo > new hi: found=0, err=0, go to DONE. Otherwise stay in PROBE; the next guess is presented the next cycle.
- DONE: done=1 for exactly one cycle; guess_valid=0, busy=0; then go to IDLE. start in DONE is ignored.
- Latency: one verdict per cycle at best. A consistent comparator needs at most WIDTH+1 probes.
- Verdicts arriving while guess_valid=0 are ignored. start while busy is ignored.

Optional Feature:
- SAR_TIMEOUT_EN defined: a wait counter clears on entry to PROBE and on each consumed verdict, and increments each PROBE cycle with cmp_valid=0. On reaching TIMEOUT: err=1, found=0, go to DONE; probes is not incremented.
- SAR_TIMEOUT_EN undefined: no counter; PROBE waits indefinitely.

Test Plan:
- WIDTH=4, target 5, ideal comparator responding same cycle -> guesses -1,3,5; done with found=1, result=5, probes=3, err=0.
- Target -8 -> guesses -1,-5,-7,-8; found=1, result=-8, probes=4.
- Target 7 -> guesses -1,3,5,6,7; found=1, result=7, probes=5 (worst case).
- Comparator always asserts cmp_gt -> guesses -1,3,5,6,7; done with found=0, err=0, probes=5. Then flags gt+eq together on the first probe -> err=1, probes=1.
- Comparator delays cmp_valid 3 cycles per probe, start pulsed mid-search, rst_n dropped during the second probe -> guess stable while waiting; start ignored; all outputs 0 at once, no done pulse; a fresh start after release behaves normally.
- SAR_TIMEOUT_EN, TIMEOUT=15, cmp_valid never asserted -> done after 15 PROBE cycles with err=1, found=0, probes=0; without the macro -> busy stays 1.

Source files
------------

// File: rtl/sar_search.sv
// sar_search: binary-search initiator driving a signed gt/lt/eq comparator through a valid handshake.
// Define SAR_TIMEOUT_EN to abort a probe after TIMEOUT cycles without a verdict.
module sar_search #(
  parameter int WIDTH   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  output logic signed [WIDTH-1:0]        guess,
  output logic                           guess_valid,
  input  logic                           cmp_valid,
  input  logic                           cmp_gt,
  input  logic                           cmp_lt,
  input  logic                           cmp_eq,
  output logic                           busy,
  output logic                           done,
  output logic                           found,
  output logic                           err,
  output logic signed [WIDTH-1:0]        result,
  output logic [$clog2(WIDTH+2)-1:0]     probes
);
  localparam int PW = $clog2(WIDTH+2);
  typedef enum logic [1:0] {S_IDLE, S_PROBE, S_DONE} state_t;
  state_t r_state, w_state;
  logic signed [WIDTH:0] r_lo, r_hi, w_lo, w_hi, w_gp1, w_gm1;
  logic signed [WIDTH+1:0] w_sum;
  logic signed [WIDTH-1:0] w_guess, r_result, w_result;
  logic [PW-1:0] r_probes, w_probes;
  logic r_found, r_err, w_found, w_err;
  logic [2:0] w_flags;
  logic w_unused;
`ifdef SAR_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT+1);
  logic [TW-1:0] r_wait, w_wait;
`endif
  // Midpoint floors toward minus infinity: bits [WIDTH:1] of the widened sum equal (sum >>> 1) truncated.
  assign w_sum    = {r_lo[WIDTH], r_lo} + {r_hi[WIDTH], r_hi};
  assign w_guess  = w_sum[WIDTH:1];
  assign w_unused = ^{w_sum[WIDTH+1], w_sum[0]};
  assign w_gp1    = {w_guess[WIDTH-1], w_guess} + (WIDTH+1)'(1);
  assign w_gm1    = {w_guess[WIDTH-1], w_guess} - (WIDTH+1)'(1);
  assign w_flags  = {cmp_gt, cmp_lt, cmp_eq};
  assign busy        = r_state == S_PROBE;
  assign guess_valid = busy;
  assign done        = r_state == S_DONE;
  assign guess       = busy ? w_guess : '0;
  assign found       = r_found;
  assign err         = r_err;
  assign result      = r_result;
  assign probes      = r_probes;
  always_comb begin
    w_state  = r_state;
    w_lo     = r_lo;
    w_hi     = r_hi;
    w_found  = r_found;
    w_err    = r_err;
    w_result = r_result;
    w_probes = r_probes;
`ifdef SAR_TIMEOUT_EN
    w_wait   = r_wait;
`endif
    unique case (r_state)
      S_IDLE: if (start) begin
        w_state  = S_PROBE;
        w_lo     = {2'b11, {(WIDTH-1){1'b0}}};
        w_hi     = {2'b00, {(WIDTH-1){1'b1}}};
        w_probes = '0;
        w_found  = 1'b0;
        w_err    = 1'b0;
        w_result = '0;
`ifdef SAR_TIMEOUT_EN
        w_wait   = '0;
`endif
      end
      S_PROBE: if (cmp_valid) begin
        w_probes = r_probes + PW'(1);
`ifdef SAR_TIMEOUT_EN
        w_wait   = '0;
`endif
        if (!$onehot(w_flags)) begin
          w_err   = 1'b1;
          w_found = 1'b0;
          w_state = S_DONE;
        end else if (cmp_eq) begin
          w_result = w_guess;
          w_found  = 1'b1;
          w_state  = S_DONE;
        end else if (cmp_gt) begin
          w_lo    = w_gp1;
          w_state = w_gp1 > r_hi ? S_DONE : S_PROBE;
        end else begin
          w_hi    = w_gm1;
          w_state = w_gm1 < r_lo ? S_DONE : S_PROBE;
        end
      end
`ifdef SAR_TIMEOUT_EN
      else if (r_wait == TW'(TIMEOUT-1)) begin
        w_err   = 1'b1;
        w_found = 1'b0;
        w_state = S_DONE;
      end else w_wait = r_wait + TW'(1);
`endif
      S_DONE: w_state = S_IDLE;
      default: w_state = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_lo     <= '0;
      r_hi     <= '0;
      r_found  <= 1'b0;
      r_err    <= 1'b0;
      r_result <= '0;
      r_probes <= '0;
`ifdef SAR_TIMEOUT_EN
      r_wait   <= '0;
`endif
    end else begin
      r_state  <= w_state;
      r_lo     <= w_lo;
      r_hi     <= w_hi;
      r_found  <= w_found;
      r_err    <= w_err;
      r_result <= w_result;
      r_probes <= w_probes;
`ifdef SAR_TIMEOUT_EN
      r_wait   <= w_wait;
`endif
    end
  end
endmodule

// File: tb/tb_sar_search.sv
// tb_sar_search: directed table vectors plus hand sequences for delayed verdicts, mid-search reset and timeout.
module tb_sar_search;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic cmp_valid = 1'b0, cmp_gt = 1'b0, cmp_lt = 1'b0, cmp_eq = 1'b0;
  logic signed [3:0] guess, result;
  logic guess_valid, busy, done, found, err;
  logic [2:0] probes;
  int n_cmp = 0, n_bad = 0;
  always #5 clk = ~clk;
  sar_search #(.WIDTH(4), .TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .guess(guess), .guess_valid(guess_valid),
    .cmp_valid(cmp_valid), .cmp_gt(cmp_gt), .cmp_lt(cmp_lt), .cmp_eq(cmp_eq),
    .busy(busy), .done(done), .found(found), .err(err), .result(result), .probes(probes)
  );
  typedef struct {
    int mode;
    int tgt;
    int found;
    int err;
    int result;
    int probes;
    logic [19:0] seq;
  } vec_t;
  vec_t v[9];
  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic clear_cmp();
    cmp_valid = 1'b0; cmp_gt = 1'b0; cmp_lt = 1'b0; cmp_eq = 1'b0;
  endtask
  // mode 0: ideal comparator, 1: always gt, 2: gt+eq together, 3: never valid
  task automatic run(input int mode, input logic signed [3:0] tgt, input int dly,
                     output logic got_done, output logic [19:0] seq);
    int w;
    logic signed [3:0] held;
    got_done = 1'b0; seq = '0; w = 0; held = '0;
    @(negedge clk); start = 1'b1;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      start = 1'b0;
      clear_cmp();
      if (done) begin
        got_done = 1'b1;
        break;
      end
      if (guess_valid && mode != 3) begin
        if (w < dly) begin
          if (w == 0) held = guess;
          else chk("guess_stable", int'(guess), int'(held));
          w++;
        end else begin
          w = 0;
          seq = {seq[15:0], guess};
          cmp_valid = 1'b1;
          cmp_gt = mode != 0 || tgt > guess;
          cmp_lt = mode == 0 && tgt < guess;
          cmp_eq = mode == 2 || (mode == 0 && tgt == guess);
        end
      end
    end
    clear_cmp();
  endtask
  initial begin
    logic gd;
    logic [19:0] sq;
    int cnt;
    v[0] = '{0,  5, 1, 0,  5, 3, 20'h00F35};
    v[1] = '{0, -8, 1, 0, -8, 4, 20'h0FB98};
    v[2] = '{0,  7, 1, 0,  7, 5, 20'hF3567};
    v[3] = '{0,  0, 1, 0,  0, 4, 20'h0F310};
    v[4] = '{0, -1, 1, 0, -1, 1, 20'h0000F};
    v[5] = '{0,  3, 1, 0,  3, 2, 20'h000F3};
    v[6] = '{0, -3, 1, 0, -3, 3, 20'h00FBD};
    v[7] = '{1,  0, 0, 0,  0, 5, 20'hF3567};
    v[8] = '{2,  0, 0, 1,  0, 1, 20'h0000F};
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_gv", guess_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_probes", probes, 0);
    rst_n = 1'b1;
    @(negedge clk);
    cmp_valid = 1'b1; cmp_eq = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_verdict_done", done, 0);
    chk("idle_verdict_probes", probes, 0);
    clear_cmp();
    for (int i = 0; i < 9; i++) begin
      run(v[i].mode, 4'(v[i].tgt), 0, gd, sq);
      chk($sformatf("v%0d_done", i), gd, 1);
      chk($sformatf("v%0d_found", i), found, v[i].found);
      chk($sformatf("v%0d_err", i), err, v[i].err);
      chk($sformatf("v%0d_result", i), int'(result), v[i].result);
      chk($sformatf("v%0d_probes", i), probes, v[i].probes);
      chk($sformatf("v%0d_seq", i), int'(sq), int'(v[i].seq));
      @(negedge clk);
      chk($sformatf("v%0d_one_pulse", i), done, 0);
    end
    // start during DONE must not relaunch
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0; cmp_valid = 1'b1; cmp_eq = 1'b1;
    @(negedge clk); clear_cmp();
    chk("done_seen_a", done, 1);
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("start_in_done_busy", busy, 0);
    @(negedge clk);
    chk("start_in_done_busy2", busy, 0);
    // slow comparator, start mid-search, then async reset during probe two
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("slow_g0", int'(guess), -1);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("slow_g0_hold", int'(guess), -1);
    @(negedge clk);
    cmp_valid = 1'b1; cmp_gt = 1'b1;
    @(negedge clk); clear_cmp();
    chk("slow_g1", int'(guess), 3);
    chk("slow_probes", probes, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_gv", guess_valid, 0);
    chk("mid_rst_guess", int'(guess), 0);
    chk("mid_rst_probes", probes, 0);
    chk("mid_rst_found", found, 0);
    chk("mid_rst_err", err, 0);
    chk("mid_rst_result", int'(result), 0);
    cnt = 0;
    repeat (3) begin
      @(negedge clk);
      cnt += done;
    end
    chk("mid_rst_no_done", cnt, 0);
    rst_n = 1'b1;
    run(0, 4'sd5, 3, gd, sq);
    chk("post_rst_done", gd, 1);
    chk("post_rst_result", int'(result), 5);
    chk("post_rst_probes", probes, 3);
    chk("post_rst_seq", int'(sq), 'hF35);
    @(negedge clk);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    cnt = 0;
    while (busy && cnt < 60) begin
      cnt++;
      @(negedge clk);
    end
`ifdef SAR_TIMEOUT_EN
    chk("to_cycles", cnt, 15);
    chk("to_done", done, 1);
    chk("to_err", err, 1);
    chk("to_found", found, 0);
    chk("to_probes", probes, 0);
`else
    chk("no_to_busy", busy, 1);
    chk("no_to_done", done, 0);
    rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
